// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PORTS requesters.
// One transaction in flight; optional response timeout turns a hang into an error response.
//   state | meaning
//   IDLE  | waiting for any request; grants from rr_ptr upward
//   BUSY  | request held toward memory, waiting for response or timeout
//   RESP  | one-cycle response pulse to the granted port
module mem_req_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 0,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        reqValid_P,
  input  logic [NUM_PORTS*ADDR_W-1:0] reqAddress_P,
  input  logic [NUM_PORTS*DATA_W-1:0] reqDataIn_P,
  input  logic [NUM_PORTS-1:0]        reqWen_P,
  input  logic [NUM_PORTS*STRB_W-1:0] reqStrobe_P,
  output logic [NUM_PORTS-1:0]        respValid_P,
  output logic [NUM_PORTS-1:0]        respError_P,
  output logic [DATA_W-1:0]           respDataOut_P,
  output logic                        reqValid_MEM,
  output logic [ADDR_W-1:0]           reqAddress_MEM,
  output logic [DATA_W-1:0]           reqDataOut_MEM,
  output logic                        reqWen_MEM,
  output logic [STRB_W-1:0]           reqStrobe_MEM,
  input  logic                        respValid_MEM,
  input  logic [DATA_W-1:0]           respDataIn_MEM
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [TW-1:0]       cnt_q, cnt_d;

  logic                found;
  logic [IW-1:0]       sel;
  logic [TW-1:0]       cnt_inc;
  logic [NUM_PORTS-1:0] resp_oh;

  always_comb begin
    int j;
    j        = 0;
    found    = 1'b0;
    sel      = '0;
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    strb_d   = strb_q;
    vld_d    = vld_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + 1'b1;

    // First requester at or above rr_q, wrapping around.
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = (int'(rr_q) + i) % NUM_PORTS;
      if (!found && reqValid_P[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = sel;
          addr_d  = reqAddress_P[int'(sel)*ADDR_W +: ADDR_W];
          wdata_d = reqDataIn_P[int'(sel)*DATA_W +: DATA_W];
          wen_d   = reqWen_P[sel];
          strb_d  = reqStrobe_P[int'(sel)*STRB_W +: STRB_W];
          vld_d   = 1'b1;
          rr_d    = (sel == IW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A response in the cycle the count would expire still wins.
        if (respValid_MEM) begin
          rdata_d = respDataIn_MEM;
          vld_d   = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TW'(TIMEOUT)) begin
            rdata_d = '0;
            vld_d   = 1'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      strb_q  <= '0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      strb_q  <= strb_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_oh        = (state_q == RESP) ? (NUM_PORTS'(1) << gnt_q) : '0;
  assign respValid_P    = resp_oh;
  assign respError_P    = err_q ? resp_oh : '0;
  assign respDataOut_P  = rdata_q;
  assign reqValid_MEM   = vld_q;
  assign reqAddress_MEM = addr_q;
  assign reqDataOut_MEM = wdata_q;
  assign reqWen_MEM     = wen_q;
  assign reqStrobe_MEM  = strb_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: 4 ports, TIMEOUT=5, behavioural memory with programmable latency.
module tb_mem_req_arbiter;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] reqValid_P, reqWen_P;
  logic [NP*32-1:0] reqAddress_P, reqDataIn_P;
  logic [NP*4-1:0]  reqStrobe_P;
  logic [NP-1:0] respValid_P, respError_P;
  logic [31:0]   respDataOut_P;
  logic          reqValid_MEM, reqWen_MEM, respValid_MEM;
  logic [31:0]   reqAddress_MEM, reqDataOut_MEM, respDataIn_MEM;
  logic [3:0]    reqStrobe_MEM;

  mem_req_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .TIMEOUT(5)) dut (
    .clk(clk), .rst(rst),
    .reqValid_P(reqValid_P), .reqAddress_P(reqAddress_P), .reqDataIn_P(reqDataIn_P),
    .reqWen_P(reqWen_P), .reqStrobe_P(reqStrobe_P),
    .respValid_P(respValid_P), .respError_P(respError_P), .respDataOut_P(respDataOut_P),
    .reqValid_MEM(reqValid_MEM), .reqAddress_MEM(reqAddress_MEM), .reqDataOut_MEM(reqDataOut_MEM),
    .reqWen_MEM(reqWen_MEM), .reqStrobe_MEM(reqStrobe_MEM),
    .respValid_MEM(respValid_MEM), .respDataIn_MEM(respDataIn_MEM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  vec;
    logic [3:0]  err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   g_cyc[$];
  logic [31:0] g_addr[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic mem_en;
  int   mem_lat;
  logic stray_req;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] v, input logic [3:0] e, input logic [31:0] d);
    exp_t x;
    x.vec = v; x.err = e; x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [3:0] s);
    reqAddress_P[p*32 +: 32] = a;
    reqDataIn_P[p*32 +: 32]  = d;
    reqWen_P[p]              = w;
    reqStrobe_P[p*4 +: 4]    = s;
    reqValid_P[p]            = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output int gc);
    bit got;
    got = 0; gc = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (reqValid_MEM) begin got = 1; gc = cyc; end
    end
    chk("grant_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_resp(input int p, input int budget, output int rc);
    bit got;
    got = 0; rc = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (respValid_P[p]) begin got = 1; rc = cyc; end
    end
    chk($sformatf("resp_seen_p%0d", p), 64'(got), 64'd1);
    reqValid_P[p] = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_reqValid_MEM"},   64'(reqValid_MEM),   64'd0);
    chk({pfx, "_respValid_P"},    64'(respValid_P),    64'd0);
    chk({pfx, "_respError_P"},    64'(respError_P),    64'd0);
    chk({pfx, "_respDataOut_P"},  64'(respDataOut_P),  64'd0);
    chk({pfx, "_reqAddress_MEM"}, 64'(reqAddress_MEM), 64'd0);
    chk({pfx, "_reqDataOut_MEM"}, 64'(reqDataOut_MEM), 64'd0);
    chk({pfx, "_reqWen_MEM"},     64'(reqWen_MEM),     64'd0);
    chk({pfx, "_reqStrobe_MEM"},  64'(reqStrobe_MEM),  64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: responds in the mem_lat-th cycle that reqValid_MEM is seen high.
  initial begin
    int mem_cnt;
    mem_cnt = 0;
    respValid_MEM = 1'b0;
    respDataIn_MEM = '0;
    forever begin
      @(posedge clk);
      #1;
      respValid_MEM = 1'b0;
      respDataIn_MEM = '0;
      if (stray_req) begin
        respValid_MEM = 1'b1;
        respDataIn_MEM = 32'hBAD0_0BAD;
        stray_req = 1'b0;
      end else if (reqValid_MEM && mem_en) begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          respValid_MEM = 1'b1;
          respDataIn_MEM = mem_data(reqAddress_MEM);
        end
      end
      if (!reqValid_MEM) mem_cnt = 0;
    end
  end

  // Monitor: logs grants and checks every response pulse against the scoreboard.
  initial begin
    logic prev_vm;
    exp_t e;
    prev_vm = 1'b0;
    forever begin
      @(negedge clk);
      if (reqValid_MEM && !prev_vm) begin
        g_cyc.push_back(cyc);
        g_addr.push_back(reqAddress_MEM);
      end
      prev_vm = reqValid_MEM;
      if (respValid_P != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'(respValid_P), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_vec",  64'(respValid_P),   64'(e.vec));
          chk("resp_err",  64'(respError_P),   64'(e.err));
          chk("resp_data", 64'(respDataOut_P), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r, n, gi;
    int order[6];
    order = '{0, 1, 2, 3, 0, 1};
    rst = 1'b0;
    reqValid_P = '0; reqWen_P = '0; reqAddress_P = '0; reqDataIn_P = '0; reqStrobe_P = '0;
    mem_en = 1'b1; mem_lat = 1; stray_req = 1'b0;

    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b1;

    // Stray memory response while idle.
    @(negedge clk);
    stray_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_no_mem_req", 64'(reqValid_MEM), 64'd0);
    end

    // Fairness: all ports request, 1-cycle memory.
    mem_lat = 1;
    foreach (order[k]) push_exp(4'(1 << order[k]), 4'd0, mem_data(32'h100 + 32'(16 * order[k])));
    gi = g_addr.size();
    for (int p = 0; p < NP; p++) drive_port(p, 32'h100 + 32'(16 * p), 32'h0, 1'b0, 4'h0);
    n = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      @(negedge clk);
      if (respValid_P != '0) begin
        n++;
        if (n == 5) reqValid_P = 4'b0010;
        if (n == 6) reqValid_P = 4'b0000;
      end
    end
    chk("fair_resp_count", 64'(n), 64'd6);
    chk("fair_grant_count", 64'(g_addr.size() - gi), 64'd6);
    if (g_addr.size() >= gi + 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("fair_grant%0d_addr", k), 64'(g_addr[gi+k]), 64'(32'h100 + 32'(16 * order[k])));
        if (k > 0) chk($sformatf("fair_gap%0d", k), 64'(g_cyc[gi+k] - g_cyc[gi+k-1]), 64'd3);
      end
    end

    // Single read, port 1.
    @(negedge clk);
    mem_lat = 2;
    push_exp(4'b0010, 4'b0000, 32'hDEAD_BEEF);
    drive_port(1, 32'h40, 32'h0, 1'b0, 4'h0);
    wait_grant(10, g);
    chk("rd_addr", 64'(reqAddress_MEM), 64'h40);
    chk("rd_wen", 64'(reqWen_MEM), 64'd0);
    wait_resp(1, 10, r);
    chk("rd_latency", 64'(r - g), 64'd2);

    // Write with strobes, port 0; request fields scrambled after grant.
    @(negedge clk);
    mem_lat = 3;
    push_exp(4'b0001, 4'b0000, mem_data(32'h80));
    drive_port(0, 32'h80, 32'h1122_3344, 1'b1, 4'b0101);
    wait_grant(10, g);
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      if (reqValid_MEM) begin
        chk("wr_addr", 64'(reqAddress_MEM), 64'h80);
        chk("wr_data", 64'(reqDataOut_MEM), 64'h1122_3344);
        chk("wr_wen",  64'(reqWen_MEM),     64'd1);
        chk("wr_strb", 64'(reqStrobe_MEM),  64'b0101);
      end
      reqAddress_P[31:0] = 32'hFFFF_FFF0;
      reqDataIn_P[31:0]  = 32'h0;
      reqWen_P[0]        = 1'b0;
      reqStrobe_P[3:0]   = 4'hF;
      @(negedge clk);
      if (respValid_P[0]) n = 1;
    end
    chk("wr_resp_seen", 64'(n), 64'd1);
    reqValid_P[0] = 1'b0;

    // Timeout: memory silent on port 2.
    @(negedge clk);
    mem_en = 1'b0;
    push_exp(4'b0100, 4'b0100, 32'h0);
    drive_port(2, 32'h200, 32'h0, 1'b0, 4'h0);
    wait_grant(10, g);
    wait_resp(2, 20, r);
    chk("tmo_busy_cycles", 64'(r - g), 64'd5);
    mem_en = 1'b1;

    // Response in the cycle the count would expire is normal.
    @(negedge clk);
    mem_lat = 5;
    push_exp(4'b0100, 4'b0000, mem_data(32'h204));
    drive_port(2, 32'h204, 32'h0, 1'b0, 4'h0);
    wait_grant(10, g);
    wait_resp(2, 20, r);
    chk("tmo_edge_latency", 64'(r - g), 64'd5);

    @(negedge clk);
    mem_lat = 2;
    push_exp(4'b0100, 4'b0000, mem_data(32'h208));
    drive_port(2, 32'h208, 32'h0, 1'b0, 4'h0);
    wait_resp(2, 20, r);

    // Reset while BUSY on port 1, then a late memory response.
    @(negedge clk);
    mem_en = 1'b0;
    drive_port(1, 32'h300, 32'h0, 1'b0, 4'h0);
    wait_grant(10, g);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("busy_rst");
    rst = 1'b1;
    reqValid_P = '0;
    mem_en = 1'b1;
    stray_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(reqValid_MEM), 64'd0);
    end

    // Ports 0 and 2 together: pointer was cleared, so port 0 first.
    mem_lat = 1;
    push_exp(4'b0001, 4'b0000, mem_data(32'h400));
    push_exp(4'b0100, 4'b0000, mem_data(32'h408));
    gi = g_addr.size();
    drive_port(0, 32'h400, 32'h0, 1'b0, 4'h0);
    drive_port(2, 32'h408, 32'h0, 1'b0, 4'h0);
    wait_resp(0, 20, r);
    if (g_addr.size() > gi) chk("rr_after_rst", 64'(g_addr[gi]), 64'h400);
    else chk("rr_after_rst_grant", 64'(g_addr.size() - gi), 64'd1);
    wait_resp(2, 20, r);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
